// File: rtl/global_lock_arbiter_pkg.sv
// Shared definitions for the global lock arbiter: FSM state encoding, owner codes
// and default memory geometry.
package global_lock_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W   = 6;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_MAX_HOLD = 255;

    localparam logic [1:0] OWNER_NONE  = 2'b00;
    localparam logic [1:0] OWNER_CORE0 = 2'b01;
    localparam logic [1:0] OWNER_CORE1 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    function automatic logic [1:0] owner_code(input state_e s);
        case (s)
            OWN0:    return OWNER_CORE0;
            OWN1:    return OWNER_CORE1;
            default: return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/global_lock_arbiter_mem_2r1w.sv
// Global data memory: two synchronous read ports, one write port, read-before-write.
// Array contents survive reset; only the read registers are cleared.
module global_mem_2r1w
    import global_lock_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr0_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o
);

    logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0_o <= '0;
            rdata1_o <= '0;
        end else begin
            rdata0_o <= mem_q[raddr0_i];
            rdata1_o <= mem_q[raddr1_i];
        end
    end

endmodule

// File: rtl/global_lock_arbiter.sv
// Two-core mutual-exclusion lock arbiter with hold watchdog, owner-filtered write
// port and per-core registered read-back of the shared global memory.
module global_lock_arbiter
    import global_lock_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              need_lock_0,
    input  logic              need_lock_1,
    input  logic [ADDR_W-1:0] gaddress_0,
    input  logic [ADDR_W-1:0] gaddress_1,
    input  logic [DATA_W-1:0] gdata_0,
    input  logic [DATA_W-1:0] gdata_1,
    input  logic              gwren_0,
    input  logic              gwren_1,
    output logic              lock_0,
    output logic              lock_1,
    output logic [DATA_W-1:0] gq_0,
    output logic [DATA_W-1:0] gq_1,
    output logic [1:0]        owner,
    output logic              hold_timeout,
    output logic              wr_conflict
);

    localparam int unsigned      CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    state_e            state_q, state_d;
    logic              last_owner_q, last_owner_d;   // 1 = core 1 was granted last
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic              timeout_q, timeout_d;
    logic              conflict_q, conflict_d;
    logic              entering;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            timeout_q    <= timeout_d;
            conflict_q   <= conflict_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (need_lock_0 && need_lock_1) state_d = last_owner_q ? OWN0 : OWN1;
                else if (need_lock_0)           state_d = OWN0;
                else if (need_lock_1)           state_d = OWN1;
            end
            OWN0: if (!need_lock_0) state_d = need_lock_1 ? OWN1 : IDLE;
            OWN1: if (!need_lock_1) state_d = need_lock_0 ? OWN0 : IDLE;
            default: state_d = IDLE;
        endcase

        // Entry includes direct handover, so the new owner gets a fresh hold window.
        entering     = (state_d != IDLE) && (state_d != state_q);
        last_owner_d = entering ? (state_d == OWN1) : last_owner_q;

        if (state_d == IDLE)            hold_cnt_d = '0;
        else if (entering)              hold_cnt_d = CNT_W'(1);
        else if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + CNT_W'(1);
        else                            hold_cnt_d = hold_cnt_q;

        timeout_d = (state_d != IDLE) && (hold_cnt_d == HOLD_MAX)
                    && (entering || (hold_cnt_q != HOLD_MAX));
    end

    always_comb begin
        we         = 1'b0;
        waddr      = gaddress_0;
        wdata      = gdata_0;
        conflict_d = 1'b0;
        case (state_q)
            OWN0: begin
                we         = gwren_0;
                conflict_d = gwren_1;
            end
            OWN1: begin
                we         = gwren_1;
                waddr      = gaddress_1;
                wdata      = gdata_1;
                conflict_d = gwren_0;
            end
            default: begin
                if (gwren_0) begin
                    we         = 1'b1;
                    conflict_d = gwren_1;
                end else if (gwren_1) begin
                    we    = 1'b1;
                    waddr = gaddress_1;
                    wdata = gdata_1;
                end
            end
        endcase
        if (rst) we = 1'b0;
    end

    global_mem_2r1w #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .raddr0_i (gaddress_0),
        .raddr1_i (gaddress_1),
        .rdata0_o (gq_0),
        .rdata1_o (gq_1)
    );

    assign lock_0       = (state_q == OWN1);
    assign lock_1       = (state_q == OWN0);
    assign owner        = owner_code(state_q);
    assign hold_timeout = timeout_q;
    assign wr_conflict  = conflict_q;

endmodule

// File: tb/tb_global_lock_arbiter.sv
// Scoreboard bench: the driver updates a cycle-level reference of the lock/memory
// rules and queues expected outputs; a monitor compares them after each edge.
module tb_global_lock_arbiter;

    localparam int MAXH = 4;

    logic        clk;
    logic        rst;
    logic        need_lock_0, need_lock_1;
    logic [5:0]  gaddress_0, gaddress_1;
    logic [31:0] gdata_0, gdata_1;
    logic        gwren_0, gwren_1;
    logic        lock_0, lock_1;
    logic [31:0] gq_0, gq_1;
    logic [1:0]  owner;
    logic        hold_timeout, wr_conflict;

    global_lock_arbiter #(
        .ADDR_W   (6),
        .DATA_W   (32),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .need_lock_0  (need_lock_0),
        .need_lock_1  (need_lock_1),
        .gaddress_0   (gaddress_0),
        .gaddress_1   (gaddress_1),
        .gdata_0      (gdata_0),
        .gdata_1      (gdata_1),
        .gwren_0      (gwren_0),
        .gwren_1      (gwren_1),
        .lock_0       (lock_0),
        .lock_1       (lock_1),
        .gq_0         (gq_0),
        .gq_1         (gq_1),
        .owner        (owner),
        .hold_timeout (hold_timeout),
        .wr_conflict  (wr_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  owner;
        logic        lock0, lock1, hto, wc;
        logic [31:0] gq0, gq1;
        bit          k0, k1;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    // Reference state: owner 0 = none, 1 = core 0, 2 = core 1.
    int          m_owner = 0;
    int          m_last  = 2;
    int          m_run   = 0;
    logic [31:0] mem_m [64];
    bit          known [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cycle, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit nl0, input bit nl1, input bit w0, input bit w1,
                        input logic [5:0] a0, input logic [5:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        exp_t e;
        int   nxt;
        int   wr_core;
        bit   drop;
        rst = r; need_lock_0 = nl0; need_lock_1 = nl1;
        gwren_0 = w0; gwren_1 = w1;
        gaddress_0 = a0; gaddress_1 = a1; gdata_0 = d0; gdata_1 = d1;
        e.hto = 1'b0; e.wc = 1'b0;
        if (r) begin
            m_owner = 0; m_last = 2; m_run = 0;
            e.gq0 = '0; e.gq1 = '0; e.k0 = 1'b1; e.k1 = 1'b1;
        end else begin
            e.gq0 = mem_m[a0]; e.k0 = known[a0];
            e.gq1 = mem_m[a1]; e.k1 = known[a1];
            wr_core = 0; drop = 1'b0;
            if (m_owner == 1) begin
                if (w0) wr_core = 1;
                drop = w1;
            end else if (m_owner == 2) begin
                if (w1) wr_core = 2;
                drop = w0;
            end else if (w0) begin
                wr_core = 1; drop = w1;
            end else if (w1) begin
                wr_core = 2;
            end
            if (wr_core == 1) begin mem_m[a0] = d0; known[a0] = 1'b1; end
            if (wr_core == 2) begin mem_m[a1] = d1; known[a1] = 1'b1; end

            if (m_owner == 1 && nl0)      nxt = 1;
            else if (m_owner == 2 && nl1) nxt = 2;
            else if (nl0 && nl1)          nxt = (m_last == 1) ? 2 : 1;
            else if (nl0)                 nxt = 1;
            else if (nl1)                 nxt = 2;
            else                          nxt = 0;
            if (nxt == 0)             m_run = 0;
            else if (nxt != m_owner) begin m_run = 1; m_last = nxt; end
            else                      m_run++;
            m_owner = nxt;
            e.hto = (m_run == MAXH);
            e.wc  = drop;
        end
        e.owner = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        e.lock0 = (m_owner == 2);
        e.lock1 = (m_owner == 1);
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("owner", {30'd0, owner}, {30'd0, e.owner});
                chk("lock_0", {31'd0, lock_0}, {31'd0, e.lock0});
                chk("lock_1", {31'd0, lock_1}, {31'd0, e.lock1});
                chk("hold_timeout", {31'd0, hold_timeout}, {31'd0, e.hto});
                chk("wr_conflict", {31'd0, wr_conflict}, {31'd0, e.wc});
                if (e.k0) chk("gq_0", gq_0, e.gq0);
                if (e.k1) chk("gq_1", gq_1, e.gq1);
            end
        end
    end

    initial begin
        bit nl0, nl1, r, w0, w1;
        logic [5:0] a0, a1;
        for (int i = 0; i < 64; i++) known[i] = 1'b0;
        rst = 1'b1; need_lock_0 = 1'b1; need_lock_1 = 1'b1;
        gwren_0 = 1'b0; gwren_1 = 1'b0;
        gaddress_0 = '0; gaddress_1 = '0; gdata_0 = '0; gdata_1 = '0;
        @(negedge clk);

        // reset with both requests high
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        // tie goes to core 0, then direct handover to core 1
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // exclusion while core 0 owns
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1, 5, 5, 32'hAAAA0001, 32'h55);
        step(0, 1, 0, 0, 0, 5, 5, 0, 0);
        step(0, 1, 0, 0, 0, 5, 5, 0, 0);
        // read-before-write on addr 9
        step(0, 1, 0, 1, 0, 9, 9, 32'h1, 0);
        step(0, 1, 0, 1, 0, 9, 9, 32'h12345678, 0);
        step(0, 1, 0, 0, 0, 9, 9, 0, 0);
        step(0, 1, 0, 0, 0, 9, 9, 0, 0);
        // hold watchdog while core 1 owns
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 9, 9, 0, 0);
        // reset while core 1 owns and writes
        step(0, 0, 1, 0, 1, 20, 20, 0, 32'hCAFE);
        step(1, 0, 1, 0, 1, 20, 20, 0, 32'hDEAD);
        step(0, 0, 0, 0, 0, 20, 20, 0, 0);
        step(0, 0, 0, 0, 0, 20, 20, 0, 0);

        // randomized traffic
        nl0 = 1'b0; nl1 = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) nl0 = ~nl0;
            if ($urandom_range(0, 7) == 0) nl1 = ~nl1;
            r  = ($urandom_range(0, 63) == 0);
            w0 = ($urandom_range(0, 2) == 0);
            w1 = ($urandom_range(0, 2) == 0);
            a0 = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
            step(r, nl0, nl1, w0, w1, a0, a1, $urandom, $urandom);
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
